// File: rtl/amo_unit_pkg.sv
// Shared constants for the atomic-memory unit: funct5 codes, FSM encodings, helpers.
package amo_unit_pkg;

  localparam logic [4:0] AmoAdd  = 5'b00000;
  localparam logic [4:0] AmoSwap = 5'b00001;
  localparam logic [4:0] AmoLr   = 5'b00010;
  localparam logic [4:0] AmoSc   = 5'b00011;
  localparam logic [4:0] AmoXor  = 5'b00100;
  localparam logic [4:0] AmoOr   = 5'b01000;
  localparam logic [4:0] AmoAnd  = 5'b01100;
  localparam logic [4:0] AmoMin  = 5'b10000;
  localparam logic [4:0] AmoMax  = 5'b10100;
  localparam logic [4:0] AmoMinu = 5'b11000;
  localparam logic [4:0] AmoMaxu = 5'b11100;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StAck  = 2'd3;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational read-modify-write datapath for AMO instructions (.W and .D).
module amo_alu
  import amo_unit_pkg::*;
(
  input  logic [4:0]  funct5,
  input  logic        w,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);

  logic [63:0] op_a, op_b, res;
  logic        lt_s, lt_u;

  always_comb begin
    op_a = w ? sext32(a[31:0]) : a;
    op_b = w ? sext32(b[31:0]) : b;
    // Sign-extended .W operands compare correctly as 64-bit signed; unsigned needs raw bits.
    lt_s = $signed(op_a) < $signed(op_b);
    lt_u = w ? (a[31:0] < b[31:0]) : (a < b);
    case (funct5)
      AmoAdd:  res = op_a + op_b;
      AmoXor:  res = op_a ^ op_b;
      AmoAnd:  res = op_a & op_b;
      AmoOr:   res = op_a | op_b;
      AmoMin:  res = lt_s ? op_a : op_b;
      AmoMax:  res = lt_s ? op_b : op_a;
      AmoMinu: res = lt_u ? op_a : op_b;
      AmoMaxu: res = lt_u ? op_b : op_a;
      default: res = op_b;
    endcase
    result = w ? sext32(res[31:0]) : res;
  end

endmodule

// File: rtl/amo_unit.sv
// RV64A atomic responder: LR/SC reservation plus AMO read-modify-write over a simple data bus.
module amo_unit
  import amo_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        amo_req,
  input  logic [4:0]  amo_funct5,
  input  logic        amo_w,
  input  logic [63:0] amo_addr,
  input  logic [63:0] amo_rs2,
  output logic        amo_ack,
  output logic [63:0] amo_rd,
  output logic        amo_err,
  output logic [63:0] b_addr,
  output logic        b_rd,
  output logic        b_wr,
  output logic        b_w,
  output logic [63:0] b_wdata,
  input  logic [63:0] b_rdata,
  input  logic        b_rdy,
  input  logic        snoop_v,
  input  logic [63:0] snoop_addr
);

  logic [1:0]  state_q, state_d;
  logic [4:0]  funct5_q;
  logic        w_q;
  logic [63:0] addr_q, rs2_q, rd_q;
  logic        err_q;
  logic        resv_v_q;
  logic [60:0] resv_addr_q;

  logic        misaligned, req_is_sc, snoop_hit, sc_hit, accept, lr_done, bus_act;
  logic [63:0] rdata_ext, alu_result;
  logic        unused_snoop_low;

  assign unused_snoop_low = ^snoop_addr[2:0];

  assign accept     = (state_q == StIdle) && amo_req;
  assign misaligned = amo_w ? (amo_addr[1:0] != 2'b00) : (amo_addr[2:0] != 3'b000);
  assign req_is_sc  = (amo_funct5 == AmoSc);
  assign snoop_hit  = snoop_v && resv_v_q && (snoop_addr[63:3] == resv_addr_q);
  // A same-cycle snoop beats the SC, so it is folded into the hit test.
  assign sc_hit     = resv_v_q && !snoop_hit && (resv_addr_q == amo_addr[63:3]);
  assign rdata_ext  = w_q ? sext32(b_rdata[31:0]) : b_rdata;
  assign lr_done    = (state_q == StRd) && b_rdy && (funct5_q == AmoLr);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (amo_req) begin
          if (misaligned)     state_d = StAck;
          else if (req_is_sc) state_d = sc_hit ? StWr : StAck;
          else                state_d = StRd;
        end
      end
      StRd:    if (b_rdy) state_d = (funct5_q == AmoLr) ? StAck : StWr;
      StWr:    if (b_rdy) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      funct5_q <= 5'b0;
      w_q      <= 1'b0;
      addr_q   <= 64'b0;
      rs2_q    <= 64'b0;
      rd_q     <= 64'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct5_q <= amo_funct5;
        w_q      <= amo_w;
        addr_q   <= amo_addr;
        rs2_q    <= amo_rs2;
        err_q    <= misaligned;
        rd_q     <= {63'b0, !misaligned && req_is_sc && !sc_hit};
      end else if ((state_q == StRd) && b_rdy) begin
        rd_q <= rdata_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_v_q    <= 1'b0;
      resv_addr_q <= 61'b0;
    end else if (lr_done) begin
      resv_v_q    <= 1'b1;
      resv_addr_q <= addr_q[63:3];
    end else if (snoop_hit || (accept && req_is_sc)) begin
      resv_v_q <= 1'b0;
    end
  end

  amo_alu u_alu (
    .funct5 (funct5_q),
    .w      (w_q),
    .a      (rd_q),
    .b      (rs2_q),
    .result (alu_result)
  );

  assign bus_act = (state_q == StRd) || (state_q == StWr);
  assign b_rd    = (state_q == StRd);
  assign b_wr    = (state_q == StWr);
  assign b_addr  = bus_act ? addr_q : 64'b0;
  assign b_w     = bus_act && w_q;
  assign b_wdata = b_wr ? ((funct5_q == AmoSc) ? rs2_q : alu_result) : 64'b0;
  assign amo_ack = (state_q == StAck);
  assign amo_rd  = amo_ack ? rd_q : 64'b0;
  assign amo_err = amo_ack && err_q;

endmodule

// File: tb/tb_amo_unit.sv
// Self-checking bench for amo_unit: directed scenarios plus randomized traffic vs a behavioural model.
module tb_amo_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        amo_req = 1'b0;
  logic [4:0]  amo_funct5 = '0;
  logic        amo_w = 1'b0;
  logic [63:0] amo_addr = '0;
  logic [63:0] amo_rs2 = '0;
  logic        amo_ack;
  logic [63:0] amo_rd;
  logic        amo_err;
  logic [63:0] b_addr;
  logic        b_rd;
  logic        b_wr;
  logic        b_w;
  logic [63:0] b_wdata;
  logic [63:0] b_rdata = '0;
  logic        b_rdy = 1'b0;
  logic        snoop_v = 1'b0;
  logic [63:0] snoop_addr = '0;

  int checks = 0;
  int errors = 0;

  amo_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .amo_req    (amo_req),
    .amo_funct5 (amo_funct5),
    .amo_w      (amo_w),
    .amo_addr   (amo_addr),
    .amo_rs2    (amo_rs2),
    .amo_ack    (amo_ack),
    .amo_rd     (amo_rd),
    .amo_err    (amo_err),
    .b_addr     (b_addr),
    .b_rd       (b_rd),
    .b_wr       (b_wr),
    .b_w        (b_w),
    .b_wdata    (b_wdata),
    .b_rdata    (b_rdata),
    .b_rdy      (b_rdy),
    .snoop_v    (snoop_v),
    .snoop_addr (snoop_addr)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] F_ADD = 5'b00000, F_SWAP = 5'b00001, F_LR = 5'b00010, F_SC = 5'b00011;
  localparam logic [4:0] F_MIN = 5'b10000, F_MINU = 5'b11000;

  // Memory as 32-bit words, reservation as (valid, doubleword index).
  logic [31:0] mem [logic [61:0]];
  bit          resv_v = 0;
  logic [60:0] resv_a = '0;

  // Bus responder bookkeeping.
  bit          rand_wait = 0;
  bit          hold_wr = 0;
  int          wait_cnt = 0;
  int          rd_hs, wr_hs, stall_cyc, strobe_cyc;
  logic [63:0] hs_addr, hs_wdata;
  logic        hs_w;

  function automatic logic [31:0] mem32(input logic [63:0] a);
    logic [61:0] k;
    k = a[63:2];
    if (!mem.exists(k)) mem[k] = $urandom;
    return mem[k];
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      b_rdy = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
        continue;
      end
      if (b_rd || b_wr) begin
        strobe_cyc++;
        if ((b_wr && hold_wr) || wait_cnt > 0) begin
          if (wait_cnt > 0) wait_cnt--;
          stall_cyc++;
        end else begin
          b_rdy   = 1'b1;
          hs_addr = b_addr;
          hs_w    = b_w;
          if (b_rd) begin
            rd_hs++;
            b_rdata = b_w ? {$urandom, mem32(b_addr)} : {mem32(b_addr + 64'd4), mem32(b_addr)};
          end else begin
            wr_hs++;
            hs_wdata = b_wdata;
            mem[b_addr[63:2]] = b_wdata[31:0];
            if (!b_w) mem[b_addr[63:2] + 62'd1] = b_wdata[63:32];
          end
          wait_cnt = rand_wait ? int'($urandom_range(0, 2)) : 0;
        end
      end
    end
  end

  function automatic void model_snoop(input logic [63:0] a);
    if (resv_v && a[63:3] == resv_a) resv_v = 0;
  endfunction

  // Expected outcome of one atomic, computed from the instruction semantics.
  function automatic void model_op(input logic [4:0] f5, input bit w, input logic [63:0] addr,
                                   input logic [63:0] rs2, output logic [63:0] e_rd,
                                   output bit e_err, output int e_rdb, output int e_wrb,
                                   output logic [63:0] e_wdata, output int e_base);
    bit hit, mis;
    logic [63:0] old;
    logic [31:0] r32;
    logic [63:0] r64;
    e_err = 0; e_rdb = 0; e_wrb = 0; e_wdata = '0; e_rd = '0;
    hit = resv_v && (resv_a == addr[63:3]);
    if (f5 == F_SC) resv_v = 0;
    mis = w ? (addr[1:0] != 0) : (addr[2:0] != 0);
    if (mis) begin
      e_err = 1; e_base = 1;
      return;
    end
    if (f5 == F_SC) begin
      if (hit) begin e_wrb = 1; e_wdata = rs2; e_base = 2; end
      else begin e_rd = 64'd1; e_base = 1; end
      return;
    end
    old = w ? sx(mem32(addr)) : {mem32(addr + 64'd4), mem32(addr)};
    e_rd = old; e_rdb = 1;
    if (f5 == F_LR) begin
      resv_v = 1; resv_a = addr[63:3]; e_base = 2;
      return;
    end
    e_wrb = 1; e_base = 3;
    if (w) begin
      case (f5)
        5'b00000: r32 = old[31:0] + rs2[31:0];
        5'b00100: r32 = old[31:0] ^ rs2[31:0];
        5'b01100: r32 = old[31:0] & rs2[31:0];
        5'b01000: r32 = old[31:0] | rs2[31:0];
        5'b10000: r32 = ($signed(old[31:0]) < $signed(rs2[31:0])) ? old[31:0] : rs2[31:0];
        5'b10100: r32 = ($signed(old[31:0]) > $signed(rs2[31:0])) ? old[31:0] : rs2[31:0];
        5'b11000: r32 = (old[31:0] < rs2[31:0]) ? old[31:0] : rs2[31:0];
        5'b11100: r32 = (old[31:0] > rs2[31:0]) ? old[31:0] : rs2[31:0];
        default:  r32 = rs2[31:0];
      endcase
      e_wdata = sx(r32);
    end else begin
      case (f5)
        5'b00000: r64 = old + rs2;
        5'b00100: r64 = old ^ rs2;
        5'b01100: r64 = old & rs2;
        5'b01000: r64 = old | rs2;
        5'b10000: r64 = ($signed(old) < $signed(rs2)) ? old : rs2;
        5'b10100: r64 = ($signed(old) > $signed(rs2)) ? old : rs2;
        5'b11000: r64 = (old < rs2) ? old : rs2;
        5'b11100: r64 = (old > rs2) ? old : rs2;
        default:  r64 = rs2;
      endcase
      e_wdata = r64;
    end
  endfunction

  // Drive one request now; count rising edges until amo_ack. With keep=1 the request stays up.
  task automatic do_amo(input logic [4:0] f5, input bit w, input logic [63:0] addr,
                        input logic [63:0] rs2, input bit keep, input bit snp,
                        input logic [63:0] saddr, output logic [63:0] o_rd, output bit o_err,
                        output int o_cyc);
    rd_hs = 0; wr_hs = 0; stall_cyc = 0; strobe_cyc = 0;
    amo_funct5 = f5; amo_w = w; amo_addr = addr; amo_rs2 = rs2; amo_req = 1'b1;
    if (snp) begin snoop_v = 1'b1; snoop_addr = saddr; end
    o_cyc = 0;
    while (o_cyc < 40) begin
      @(posedge clk); #1;
      snoop_v = 1'b0;
      o_cyc++;
      if (amo_ack) break;
    end
    checks++;
    if (amo_ack !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout f5=%b addr=%h got amo_ack=%b want 1", f5, addr, amo_ack);
    end
    o_rd = amo_rd; o_err = amo_err;
    if (!keep) begin
      amo_req = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic do_snoop(input logic [63:0] a);
    @(negedge clk);
    snoop_v = 1'b1; snoop_addr = a;
    model_snoop(a);
    @(negedge clk);
    snoop_v = 1'b0;
  endtask

  // Locals for the expected/observed values of one operation.
  logic [63:0] e_rd, e_wd, o_rd;
  bit          e_err, o_err;
  int          e_rdb, e_wrb, e_base, o_cyc;

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({amo_ack, amo_err, b_rd, b_wr, b_w} !== 5'b0 || amo_rd !== '0 || b_addr !== '0 ||
        b_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b err=%b rd=%b wr=%b w=%b rd=%h addr=%h wd=%h want all 0",
               amo_ack, amo_err, b_rd, b_wr, b_w, amo_rd, b_addr, b_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resv_v = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b_rd !== 1'b0 || b_wr !== 1'b0 || amo_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_activity got rd=%b wr=%b ack=%b want 0", b_rd, b_wr, amo_ack);
    end
  endtask

  task automatic test_amoadd();
    mem[62'h1000 >> 2] = 32'd5; mem[62'h1004 >> 2] = 32'd0;
    @(negedge clk);
    model_op(F_ADD, 0, 64'h1000, 64'd7, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_ADD, 0, 64'h1000, 64'd7, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_rd !== 64'd5) begin errors++; $display("FAIL amoadd_rd got %h want 5", o_rd); end
    checks++;
    if (hs_wdata !== 64'd12 || wr_hs !== 1) begin
      errors++; $display("FAIL amoadd_wdata got %h (wr %0d) want 12 (wr 1)", hs_wdata, wr_hs);
    end
    checks++;
    if (o_cyc !== 3) begin errors++; $display("FAIL amoadd_latency got %0d want 3", o_cyc); end
  endtask

  task automatic test_min_minu();
    mem[62'h1100 >> 2] = 32'hFFFF_FFFF;
    @(negedge clk);
    model_op(F_MIN, 1, 64'h1100, 64'd1, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_MIN, 1, 64'h1100, 64'd1, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (hs_wdata[31:0] !== 32'hFFFF_FFFF || o_rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL amomin_w got wd=%h rd=%h want ffffffff / all ones", hs_wdata, o_rd);
    end
    mem[62'h1100 >> 2] = 32'hFFFF_FFFF;
    @(negedge clk);
    model_op(F_MINU, 1, 64'h1100, 64'd1, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_MINU, 1, 64'h1100, 64'd1, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (hs_wdata[31:0] !== 32'd1 || hs_w !== 1'b1) begin
      errors++; $display("FAIL amominu_w got wd=%h w=%b want 1 / 1", hs_wdata, hs_w);
    end
  endtask

  task automatic test_lr_sc();
    @(negedge clk);
    model_op(F_LR, 0, 64'h2000, '0, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_LR, 0, 64'h2000, '0, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_rd !== e_rd || o_cyc !== 2) begin
      errors++; $display("FAIL lr_d got rd=%h cyc=%0d want %h / 2", o_rd, o_cyc, e_rd);
    end
    @(negedge clk);
    model_op(F_SC, 0, 64'h2000, 64'hDEAD_BEEF_1234_5678, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_SC, 0, 64'h2000, 64'hDEAD_BEEF_1234_5678, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_rd !== 64'd0 || wr_hs !== 1 || hs_wdata !== 64'hDEAD_BEEF_1234_5678 || o_cyc !== 2) begin
      errors++;
      $display("FAIL sc_success got rd=%h wr=%0d wd=%h cyc=%0d want 0 / 1 / deadbeef12345678 / 2",
               o_rd, wr_hs, hs_wdata, o_cyc);
    end
    @(negedge clk);
    model_op(F_SC, 0, 64'h2000, 64'd9, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_SC, 0, 64'h2000, 64'd9, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_rd !== 64'd1 || strobe_cyc !== 0 || o_cyc !== 1) begin
      errors++;
      $display("FAIL sc_second got rd=%h strobes=%0d cyc=%0d want 1 / 0 / 1", o_rd, strobe_cyc, o_cyc);
    end
  endtask

  task automatic test_snoop();
    logic [63:0] saddrs [3];
    logic [63:0] want [3];
    saddrs[0] = 64'h2004; saddrs[1] = 64'h2008; saddrs[2] = 64'h2000;
    want[0] = 64'd1; want[1] = 64'd0; want[2] = 64'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_op(F_LR, 0, 64'h2000, '0, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
      do_amo(F_LR, 0, 64'h2000, '0, 0, 0, '0, o_rd, o_err, o_cyc);
      if (i < 2) do_snoop(saddrs[i]);
      @(negedge clk);
      if (i == 2) model_snoop(saddrs[i]);
      model_op(F_SC, 0, 64'h2000, 64'd77, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
      do_amo(F_SC, 0, 64'h2000, 64'd77, 0, i == 2, saddrs[i], o_rd, o_err, o_cyc);
      checks++;
      if (o_rd !== want[i] || wr_hs !== int'(want[i] == 0)) begin
        errors++;
        $display("FAIL snoop_sc_%0d got rd=%h wr=%0d want %h / %0d", i, o_rd, wr_hs, want[i],
                 int'(want[i] == 0));
      end
    end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    model_op(F_SWAP, 1, 64'h1002, 64'd3, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_SWAP, 1, 64'h1002, 64'd3, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_err !== 1'b1 || o_rd !== 64'd0 || o_cyc !== 1 || strobe_cyc !== 0) begin
      errors++;
      $display("FAIL misaligned_w got err=%b rd=%h cyc=%0d strobes=%0d want 1 / 0 / 1 / 0",
               o_err, o_rd, o_cyc, strobe_cyc);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    model_op(F_LR, 0, 64'h2000, '0, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_LR, 0, 64'h2000, '0, 0, 0, '0, o_rd, o_err, o_cyc);
    @(negedge clk);
    hold_wr = 1;
    amo_funct5 = F_SWAP; amo_w = 1'b0; amo_addr = 64'h2000; amo_rs2 = 64'd1; amo_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b_wr !== 1'b1) begin errors++; $display("FAIL held_write got b_wr=%b want 1", b_wr); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (b_wr !== 1'b0 || b_rd !== 1'b0 || b_addr !== '0 || b_w !== 1'b0 || amo_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_drop got wr=%b rd=%b addr=%h w=%b ack=%b want 0", b_wr, b_rd,
               b_addr, b_w, amo_ack);
    end
    amo_req = 1'b0; hold_wr = 0;
    resv_v = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_op(F_SC, 0, 64'h2000, 64'd5, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_SC, 0, 64'h2000, 64'd5, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_rd !== 64'd1 || strobe_cyc !== 0) begin
      errors++; $display("FAIL sc_after_reset got rd=%h strobes=%0d want 1 / 0", o_rd, strobe_cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rs;
    @(negedge clk);
    rs = {$urandom, $urandom};
    model_op(F_ADD, 0, 64'h3000, rs, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_ADD, 0, 64'h3000, rs, 1, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    if (o_rd !== e_rd || o_cyc !== 3) begin
      errors++; $display("FAIL b2b_first got rd=%h cyc=%0d want %h / 3", o_rd, o_cyc, e_rd);
    end
    model_op(F_LR, 0, 64'h3000, '0, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
    do_amo(F_LR, 0, 64'h3000, '0, 0, 0, '0, o_rd, o_err, o_cyc);
    checks++;
    // One extra edge: the ACK->IDLE transition precedes acceptance.
    if (o_rd !== e_rd || o_cyc !== 3) begin
      errors++; $display("FAIL b2b_second got rd=%h cyc=%0d want %h / 3", o_rd, o_cyc, e_rd);
    end
  endtask

  task automatic test_random();
    logic [4:0]  codes [16];
    logic [4:0]  f5;
    logic [63:0] addr, rs2;
    bit          w;
    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000, 5'b01100, 5'b10000,
              5'b10100, 5'b11000, 5'b11100, 5'b00101, 5'b11111, 5'b00010, 5'b00011, 5'b00011};
    rand_wait = 1;
    for (int n = 0; n < 120; n++) begin
      f5   = codes[$urandom_range(0, 15)];
      w    = 1'($urandom_range(0, 1));
      addr = 64'h4000 + 64'(8 * $urandom_range(0, 3));
      if (w) addr += 64'(4 * $urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) addr += 64'($urandom_range(1, 3));
      else if (!w && $urandom_range(0, 9) == 0) addr += 64'd4;
      rs2 = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) do_snoop(64'h4000 + 64'($urandom_range(0, 31)));
      @(negedge clk);
      model_op(f5, w, addr, rs2, e_rd, e_err, e_rdb, e_wrb, e_wd, e_base);
      do_amo(f5, w, addr, rs2, 0, 0, '0, o_rd, o_err, o_cyc);
      checks++;
      if (o_rd !== e_rd || o_err !== e_err) begin
        errors++;
        $display("FAIL rand_result n=%0d f5=%b w=%b addr=%h got rd=%h err=%b want rd=%h err=%b",
                 n, f5, w, addr, o_rd, o_err, e_rd, e_err);
      end
      checks++;
      if (rd_hs !== e_rdb || wr_hs !== e_wrb || o_cyc !== e_base + stall_cyc) begin
        errors++;
        $display("FAIL rand_bus n=%0d f5=%b got rd=%0d wr=%0d cyc=%0d want rd=%0d wr=%0d cyc=%0d",
                 n, f5, rd_hs, wr_hs, o_cyc, e_rdb, e_wrb, e_base + stall_cyc);
      end
      if (e_wrb == 1) begin
        checks++;
        if ((w ? (hs_wdata[31:0] !== e_wd[31:0]) : (hs_wdata !== e_wd)) || hs_addr !== addr ||
            hs_w !== w) begin
          errors++;
          $display("FAIL rand_write n=%0d f5=%b got wd=%h addr=%h w=%b want wd=%h addr=%h w=%b",
                   n, f5, hs_wdata, hs_addr, hs_w, e_wd, addr, w);
        end
      end
    end
    rand_wait = 0;
  endtask

  initial begin
    test_reset();
    test_amoadd();
    test_min_minu();
    test_lr_sc();
    test_snoop();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule
